// File: rtl/div_unit_seq.sv
// Multi-cycle RV32M divide unit: radix-2 restoring divider with one op in flight.
// It accepts an op from the reservation station and holds the result until the CDB grants it.
module div_unit_seq #(
    parameter int XLEN     = 32,
    parameter int ROB_ID_W = 3,
    parameter int PREG_W   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_div_type,
    input  logic [XLEN-1:0]     req_a,
    input  logic [XLEN-1:0]     req_b,
    input  logic [ROB_ID_W-1:0] req_rob_id,
    input  logic [PREG_W-1:0]   req_prd,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_value,
    output logic [ROB_ID_W-1:0] resp_rob_id,
    output logic [PREG_W-1:0]   resp_prd,
    output logic                busy
);
    localparam int CNT_W = $clog2(XLEN);

    // valid/ready: a transfer happens on a rising edge where valid && ready are both high.
    // The payload must stay stable while valid is high and ready is low.
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [XLEN-1:0]    divisor;
    logic [XLEN-1:0]    quo;
    logic [XLEN:0]      prem;
    logic               neg_res;
    logic               is_rem;

    logic               signed_op;
    logic               rem_op;
    logic               a_neg;
    logic               b_neg;
    logic [XLEN-1:0]    abs_a;
    logic [XLEN-1:0]    abs_b;
    logic               div_zero;
    logic               ovf;

    logic [XLEN:0]      shifted;
    logic [XLEN:0]      trial;
    logic               q_bit;
    logic [XLEN:0]      next_rem;
    logic [XLEN-1:0]    next_quo;
    logic [XLEN-1:0]    raw;
    logic [XLEN-1:0]    fixed;

    assign req_ready  = (state == S_IDLE) && !flush;
    assign resp_valid = (state == S_DONE);
    assign busy       = (state != S_IDLE);

    always_comb begin
        signed_op = ~req_div_type[0];
        rem_op    = req_div_type[1];
        a_neg     = signed_op && req_a[XLEN-1];
        b_neg     = signed_op && req_b[XLEN-1];
        abs_a     = a_neg ? (~req_a + 1'b1) : req_a;
        abs_b     = b_neg ? (~req_b + 1'b1) : req_b;
        div_zero  = (req_b == '0);
        ovf       = signed_op && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
    end

    // One restoring step; the partial remainder stays below the divisor, so its low XLEN bits suffice.
    always_comb begin
        shifted  = {prem[XLEN-1:0], quo[XLEN-1]};
        trial    = shifted - {1'b0, divisor};
        q_bit    = ~trial[XLEN];
        next_rem = q_bit ? trial : shifted;
        next_quo = {quo[XLEN-2:0], q_bit};
        raw      = is_rem ? next_rem[XLEN-1:0] : next_quo;
        fixed    = neg_res ? (~raw + 1'b1) : raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            divisor     <= '0;
            quo         <= '0;
            prem        <= '0;
            neg_res     <= 1'b0;
            is_rem      <= 1'b0;
            resp_value  <= '0;
            resp_rob_id <= '0;
            resp_prd    <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        resp_rob_id <= req_rob_id;
                        resp_prd    <= req_prd;
                        is_rem      <= rem_op;
                        if (div_zero) begin
                            resp_value <= rem_op ? req_a : '1;
                            state      <= S_DONE;
                        end else if (ovf) begin
                            resp_value <= rem_op ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                            state      <= S_DONE;
                        end else begin
                            divisor <= abs_b;
                            quo     <= abs_a;
                            prem    <= '0;
                            neg_res <= rem_op ? a_neg : (a_neg ^ b_neg);
                            cnt     <= '0;
                            state   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    prem <= next_rem;
                    quo  <= next_quo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) begin
                        resp_value <= fixed;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit_seq.sv
// Directed and randomized bench for div_unit_seq against a plain-arithmetic RV32M divide model.
module tb_div_unit_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_div_type;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_rob_id;
    logic [5:0]  req_prd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_value;
    logic [2:0]  resp_rob_id;
    logic [5:0]  resp_prd;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [40:0] exp_q[$];

    div_unit_seq #(.XLEN(32), .ROB_ID_W(3), .PREG_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_div_type(req_div_type),
        .req_a(req_a), .req_b(req_b), .req_rob_id(req_rob_id), .req_prd(req_prd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_value(resp_value),
        .resp_rob_id(resp_rob_id), .resp_prd(resp_prd), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_div(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) return t[1] ? a : 32'hFFFF_FFFF;
        if (!t[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return t[1] ? 32'd0 : 32'h8000_0000;
        case (t)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    task automatic drive_req(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] rob, input logic [5:0] prd);
        req_valid    = 1'b1;
        req_div_type = t;
        req_a        = a;
        req_b        = b;
        req_rob_id   = rob;
        req_prd      = prd;
    endtask

    // Called just after a falling edge; returns just after a falling edge with the result granted.
    task automatic do_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [2:0]  rob;
        logic [5:0]  prd;
        logic [2:0]  erob;
        logic [5:0]  eprd;
        logic [31:0] ev;
        int          lat;
        int          exp_lat;
        rob = 3'($urandom);
        prd = 6'($urandom);
        exp_q.push_back({rob, prd, ref_div(t, a, b)});
        exp_lat = (b == 32'd0 || (!t[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        drive_req(t, a, b, rob, prd);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        check("busy_after_accept", 32'(busy), 32'd1);
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        {erob, eprd, ev} = exp_q.pop_front();
        check("value", resp_value, ev);
        check("rob_id", 32'(resp_rob_id), 32'(erob));
        check("prd", 32'(resp_prd), 32'(eprd));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_value", resp_value, ev);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("valid_after_grant", 32'(resp_valid), 32'd0);
        check("ready_after_grant", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] b;
        int          seen;
        rst_n = 1'b0;
        flush = 1'b0;
        req_valid = 1'b0;
        req_div_type = 2'b00;
        req_a = '0;
        req_b = '0;
        req_rob_id = '0;
        req_prd = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_value", resp_value, 32'd0);
        check("reset_rob", 32'(resp_rob_id), 32'd0);
        check("reset_prd", 32'(resp_prd), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed normal and special cases.
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(2'b11, 32'd7, 32'd2, 0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'h10, 0);
        do_op(2'b00, 32'd5, 32'd0, 0);
        do_op(2'b10, 32'd5, 32'd0, 0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Backpressure then back-to-back issue.
        do_op(2'b00, 32'd1000, 32'hFFFF_FFFD, 10);
        do_op(2'b01, 32'd12345, 32'd11, 0);

        // Flush mid-BUSY with a competing request.
        drive_req(2'b01, 32'd1000, 32'd3, 3'd1, 6'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (14) @(negedge clk);
        flush = 1'b1;
        drive_req(2'b01, 32'd50, 32'd5, 3'd2, 6'd2);
        check("flush_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_valid", 32'(resp_valid), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        check("flush_no_resp", 32'(seen), 32'd0);
        do_op(2'b01, 32'd100, 32'd7, 0);

        // Flush beats a same-cycle grant in DONE.
        drive_req(2'b00, 32'd5, 32'd0, 3'd3, 6'd3);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("done_before_flush", 32'(resp_valid), 32'd1);
        flush = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        resp_ready = 1'b0;
        check("flush_done_valid", 32'(resp_valid), 32'd0);
        check("flush_done_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-BUSY.
        drive_req(2'b10, 32'd1234, 32'd5, 3'd4, 6'd4);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(resp_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_value", resp_value, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(2'b10, 32'd100, 32'd7, 0);

        // Randomized ops, including special operands and random backpressure.
        for (int n = 0; n < 30; n++) begin
            t = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(t, a, b, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
